// File: rtl/digit_template_matcher.sv
// digit_template_matcher: nearest-glyph digit recogniser by Hamming distance over a 16x16 bitmap.
// Optional MATCH_MARGIN_EN adds second-best tracking and a minimum-margin accept test.
module digit_template_matcher #(
  parameter int NUM_DIGITS = 10,
  parameter int MAX_DIST   = 40,
  parameter int MIN_MARGIN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  sample_addr,
  input  logic [0:15] sample_row,
  output logic [3:0]  tmpl_sel,
  output logic [3:0]  tmpl_addr,
  input  logic [0:15] tmpl_row,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit,
  output logic [8:0]  score,
  output logic        match
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [3:0] LAST = 4'(NUM_DIGITS - 1);
  localparam logic [8:0] MAXD = 9'(MAX_DIST);
  state_t state;
  logic [3:0] r, d, bdig;
  logic [8:0] acc, best, tot, nb;
  logic [4:0] pc;
  logic better, ok;
  assign sample_addr = r;
  assign tmpl_addr = r;
  assign tmpl_sel = d;
  assign pc = 5'($countones(sample_row ^ tmpl_row));
  assign tot = acc + 9'(pc);
  assign better = tot < best;
  assign nb = better ? tot : best;
`ifdef MATCH_MARGIN_EN
  localparam logic [8:0] MINM = 9'(MIN_MARGIN);
  logic [8:0] second, ns;
  // second never drops below best, so the subtraction cannot wrap
  assign ns = better ? best : (tot < second ? tot : second);
  assign ok = (nb <= MAXD) && (ns - nb >= MINM);
`else
  assign ok = nb <= MAXD;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      d <= '0;
      acc <= '0;
      best <= 9'd511;
      bdig <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      digit <= '0;
      score <= '0;
      match <= 1'b0;
`ifdef MATCH_MARGIN_EN
      second <= 9'd511;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SCAN;
          busy <= 1'b1;
          r <= '0;
          d <= '0;
          acc <= '0;
          best <= 9'd511;
          match <= 1'b0;
`ifdef MATCH_MARGIN_EN
          second <= 9'd511;
`endif
        end
        SCAN: begin
          r <= r + 4'd1;
          if (r != 4'd15) acc <= tot;
          else begin
            acc <= '0;
            best <= nb;
            bdig <= better ? d : bdig;
`ifdef MATCH_MARGIN_EN
            second <= ns;
`endif
            if (d == LAST) begin
              // d returns to 0 so the ROM addresses idle at zero
              d <= '0;
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              digit <= better ? d : bdig;
              score <= nb;
              match <= ok;
            end else d <= d + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_template_matcher.sv
// tb_digit_template_matcher: directed checks of scan timing, addressing, tie-break, reject, restart and reset.
module tb_digit_template_matcher;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] sample_addr, tmpl_sel, tmpl_addr, digit;
  logic [0:15] sample_row, tmpl_row;
  logic busy, done, match;
  logic [8:0] score;
  logic [0:15] tmpl [16][16];
  logic [0:15] smp [16];
  int n_assert = 0, n_fail = 0, dcyc, nd;

  digit_template_matcher dut (
    .clk(clk), .rst(rst), .start(start), .sample_addr(sample_addr), .sample_row(sample_row),
    .tmpl_sel(tmpl_sel), .tmpl_addr(tmpl_addr), .tmpl_row(tmpl_row), .busy(busy), .done(done),
    .digit(digit), .score(score), .match(match)
  );

  always #5 clk = ~clk;
  assign sample_row = smp[sample_addr];
  assign tmpl_row = tmpl[tmpl_sel][tmpl_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cycle k is the interval after the k-th edge counted from the start edge (k=1 first SCAN cycle)
  task automatic run(input int restart_at, input int rst_at, input bit chk_addr, output int dc, output int ndone);
    dc = 0;
    ndone = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (done === 1'b1) begin
        ndone++;
        if (dc == 0) dc = k;
      end
      if (chk_addr && k <= 160)
        chk("addr_seq", {tmpl_sel, tmpl_addr, sample_addr}, {4'((k - 1) / 16), 4'((k - 1) % 16), 4'((k - 1) % 16)});
      if (chk_addr && k == 180) chk("addr_idle", {tmpl_sel, tmpl_addr, sample_addr}, 0);
      if (chk_addr && k == 1) chk("busy_scan", busy, 1);
      if (chk_addr && k == 161) chk("busy_done", busy, 0);
      if (k == restart_at) start = 1'b1;
      if (k == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      smp[i] = '0;
      for (int j = 0; j < 16; j++) tmpl[i][j] = '0;
    end
  endtask

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_digit", digit, 0);
    chk("rst_score", score, 0);
    chk("rst_addr", {tmpl_sel, tmpl_addr, sample_addr}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_addr", {tmpl_sel, tmpl_addr, sample_addr}, 0);
    // ten shifted one-hot diagonals; sample equals glyph 9
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 16; j++) tmpl[i][j] = 16'(1) << ((i + j) % 16);
    for (int j = 0; j < 16; j++) smp[j] = tmpl[9][j];
    run(0, 0, 1'b1, dcyc, nd);
    chk("t1_done_cycle", dcyc, 161);
    chk("t1_done_count", nd, 1);
    chk("t1_digit", digit, 9);
    chk("t1_score", score, 0);
    chk("t1_match", match, 1);
    run(20, 0, 1'b0, dcyc, nd);
    chk("t4_restart_cycle", dcyc, 161);
    chk("t4_restart_count", nd, 1);
    chk("t4_digit", digit, 9);
    run(0, 50, 1'b0, dcyc, nd);
    chk("t4_rst_ndone", nd, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_digit", digit, 0);
    chk("t4_rst_score", score, 0);
    chk("t4_rst_match", match, 0);
    // all-zero sample; digits 3 and 5 tie at 30, others have 40
    clear_mem();
    for (int i = 0; i < 10; i++) begin
      tmpl[i][0] = 16'hFFFF;
      tmpl[i][1] = (i == 3 || i == 5) ? 16'hFFFC : 16'hFFFF;
      tmpl[i][2] = (i == 3 || i == 5) ? 16'h0000 : 16'hFF00;
    end
    run(0, 0, 1'b0, dcyc, nd);
    chk("t2_done_cycle", dcyc, 161);
    chk("t2_digit", digit, 3);
    chk("t2_score", score, 30);
    chk("t2_match", match, 1);
    // all-ones sample against blank templates: every total is 256
    clear_mem();
    for (int j = 0; j < 16; j++) smp[j] = 16'hFFFF;
    run(0, 0, 1'b0, dcyc, nd);
    chk("t3_digit", digit, 0);
    chk("t3_score", score, 256);
    chk("t3_match", match, 0);
    // best 10 (digit 0), second 12 (digit 1), others 54
    clear_mem();
    tmpl[0][0] = 16'hFFC0;
    tmpl[1][0] = 16'hFFF0;
    for (int i = 2; i < 10; i++) begin
      tmpl[i][0] = 16'hFFFF;
      tmpl[i][1] = 16'hFFFF;
      tmpl[i][2] = 16'hFFFF;
      tmpl[i][3] = 16'hFC00;
    end
    run(0, 0, 1'b0, dcyc, nd);
    chk("t6_digit", digit, 0);
    chk("t6_score", score, 10);
`ifdef MATCH_MARGIN_EN
    chk("t6_match", match, 0);
`else
    chk("t6_match", match, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
